dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
//   Sequences 8/16/32-bit load/store requests from the LSU onto the two byte-wide
//   ports of the 32K x 8 data RAM (dual_port_ram). Splits each access into
//   little-endian byte lanes: two bytes per cycle, A = lower byte, B = next byte.
//   Assembles load data, with sign/zero extension, and returns one response per request.
// PARAMETERS
//   ADDR_W   15   byte-address width; matches the RAM depth of 2**ADDR_W
// PORTS
//   clk           in   1       clock; all state changes on the rising edge
//   rst           in   1       asynchronous, active-high reset
//   req_valid     in   1       request present
//   req_ready     out  1       controller can accept; high only in IDLE
//   req_we        in   1       1 = store, 0 = load
//   req_size      in   2       00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  in   1       load: 1 = zero-extend, 0 = sign-extend
//   req_addr      in   ADDR_W  byte address; any alignment
//   req_wdata     in   32      store data; byte k is bits [8k+7:8k]
//   rsp_valid     out  1       one-cycle response pulse
//   rsp_rdata     out  32      load result; 0 for stores and errors
//   rsp_err       out  1       request had req_size = 11
//   ram_addr_a    out  ADDR_W  to RAM addr_a
//   ram_din_a     out  8       to RAM data_in_a
//   ram_we_a      out  1       to RAM we_a
//   ram_dout_a    in   8       from RAM data_out_a
//   ram_addr_b    out  ADDR_W  to RAM addr_b
//   ram_din_b     out  8       to RAM data_in_b
//   ram_we_b      out  1       to RAM we_b
//   ram_dout_b    in   8       from RAM data_out_b
// BEHAVIOUR
//   - Reset values: state IDLE; all RAM outputs, rsp_valid, rsp_rdata and rsp_err = 0.
//     req_ready = 1 after reset.
//   - Accept: on an edge where req_valid && req_ready. All req_* fields are registered.
//   - States and transitions:
//     - IDLE -> ACC0 for a legal size.
//     - IDLE -> IDLE for size 11: rsp_valid and rsp_err = 1 in the next cycle, no RAM access.
//     - ACC0 drives A = base, B = base+1 (B idle for byte).
//       - Word -> ACC1.
//       - Byte/half load -> WAIT.
//       - Byte/half store -> IDLE.
//     - ACC1 drives A = base+2, B = base+3.
//       - Load -> WAIT.
//       - Store -> IDLE.
//     - WAIT issues no RAM access; the last read bytes arrive this cycle. -> IDLE.
//   - Address arithmetic is modulo 2**ADDR_W: base 0x7FFF gives B = 0x0000.
//   - Store: ram_we_x = 1 only on the active lanes in ACC0/ACC1; din = the matching
//     req_wdata byte. Byte store: only A is written, ram_we_b = 0.
//   - Load: bytes 0/1 are captured from ram_dout_a/b in ACC1 (word) or WAIT (byte/half).
//     Bytes 2/3 are taken in WAIT.
//   - Load extension: extend from bit 7 (byte) or bit 15 (half) per req_unsigned.
//     A word load passes through unextended.
//   - Outside ACC0/ACC1: ram_we_a and ram_we_b = 0; RAM addr/din outputs hold 0.
//   - Response: rsp_valid, rsp_rdata and rsp_err are registered. They are set on the edge
//     leaving the final state and held for exactly one cycle.
//   - Back-to-back: req_ready = 1 in the same cycle as rsp_valid, so a new request may be
//     accepted there.
//   - Latency from the accept edge to rsp_valid:
//     - load word 4, load byte/half 3
//     - store word 3, store byte/half 2
//     - illegal 1
//   - Ports A and B never target the same address within one cycle.
//   - Reset mid-operation: return to IDLE at once; RAM we outputs drop asynchronously;
//     no response. A word store interrupted after ACC0 leaves bytes 0-1 written.
// TESTING
//   1. Store word 0xDEADBEEF @0x0100, then load word unsigned -> rsp_rdata = 0xDEADBEEF;
//      RAM[0x100..0x103] = EF,BE,AD,DE; store rsp 3 cycles and load rsp 4 cycles after accept.
//   2. Store byte 0x80 @0x0005, then load byte signed -> 0xFFFFFF80; unsigned -> 0x00000080;
//      ram_we_b never asserted during the store.
//   3. Misaligned/wrap: store half 0x1234 @0x7FFF -> RAM[0x7FFF]=34, RAM[0x0000]=12;
//      load half signed @0x7FFF -> 0x00001234.
//   4. Illegal: req_size = 11 -> rsp_valid and rsp_err = 1 the next cycle, rdata 0,
//      no ram_we and no state change.
//   5. Back-to-back: hold req_valid for 3 loads; req_ready is low in ACC0/ACC1/WAIT;
//      each request is accepted in its predecessor's rsp cycle; data is returned in order.
//   6. Assert rst during ACC1 of a word store -> ram_we low the same cycle, no rsp_valid,
//      req_ready = 1 after release, RAM[base+2..base+3] unchanged.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: splits 8/16/32-bit LSU loads and stores into little-endian
// byte-lane accesses on the two byte-wide ports of the data RAM, two bytes per
// cycle, and returns one registered response per request.
module dmem_access_ctrl #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [7:0]        ram_din_a,
  output logic              ram_we_a,
  input  logic [7:0]        ram_dout_a,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic [7:0]        ram_din_b,
  output logic              ram_we_b,
  input  logic [7:0]        ram_dout_b
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ACC0, S_ACC1, S_WAIT} state_t;

  state_t              state_q;
  logic                we_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [15:0]         rdata_lo_q;   // bytes 0/1 of a word load, captured in ACC1
  logic                rsp_valid_q;
  logic [31:0]         rsp_rdata_q;
  logic                rsp_err_q;
  logic [ADDR_W-1:0]   ram_addr_a_q;
  logic [ADDR_W-1:0]   ram_addr_b_q;
  logic [7:0]          ram_din_a_q;
  logic [7:0]          ram_din_b_q;
  logic                ram_we_a_q;
  logic                ram_we_b_q;
  logic [31:0]         load_data_d;

  assign req_ready  = (state_q == S_IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign ram_addr_a = ram_addr_a_q;
  assign ram_addr_b = ram_addr_b_q;
  assign ram_din_a  = ram_din_a_q;
  assign ram_din_b  = ram_din_b_q;
  assign ram_we_a   = ram_we_a_q;
  assign ram_we_b   = ram_we_b_q;

  // Final load value as seen in WAIT: last read bytes straight from the RAM, extended by size.
  always_comb begin
    load_data_d = 32'h0;
    case (size_q)
      SZ_BYTE: load_data_d = {{24{~uns_q & ram_dout_a[7]}}, ram_dout_a};
      2'b01:   load_data_d = {{16{~uns_q & ram_dout_b[7]}}, ram_dout_b, ram_dout_a};
      default: load_data_d = {ram_dout_b, ram_dout_a, rdata_lo_q};
    endcase
  end

  // Access sequencer: state, captured request, registered RAM drive and response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      rdata_lo_q   <= 16'h0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 32'h0;
      rsp_err_q    <= 1'b0;
      ram_addr_a_q <= '0;
      ram_addr_b_q <= '0;
      ram_din_a_q  <= 8'h0;
      ram_din_b_q  <= 8'h0;
      ram_we_a_q   <= 1'b0;
      ram_we_b_q   <= 1'b0;
    end else begin
      // Responses are single-cycle pulses and RAM drive is idle unless a state sets it.
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 32'h0;
      rsp_err_q    <= 1'b0;
      ram_addr_a_q <= '0;
      ram_addr_b_q <= '0;
      ram_din_a_q  <= 8'h0;
      ram_din_b_q  <= 8'h0;
      ram_we_a_q   <= 1'b0;
      ram_we_b_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (req_size == SZ_ILL) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else begin
              state_q      <= S_ACC0;
              // B always points one byte above A, so the ports never collide;
              // for a byte access B is simply never written and its read is ignored.
              ram_addr_a_q <= req_addr;
              ram_addr_b_q <= req_addr + ADDR_W'(1);
              ram_we_a_q   <= req_we;
              ram_we_b_q   <= req_we && (req_size != SZ_BYTE);
              ram_din_a_q  <= req_we ? req_wdata[7:0] : 8'h0;
              ram_din_b_q  <= (req_we && (req_size != SZ_BYTE)) ? req_wdata[15:8] : 8'h0;
            end
          end
        end
        S_ACC0: begin
          if (size_q == SZ_WORD) begin
            state_q      <= S_ACC1;
            ram_addr_a_q <= addr_q + ADDR_W'(2);
            ram_addr_b_q <= addr_q + ADDR_W'(3);
            ram_we_a_q   <= we_q;
            ram_we_b_q   <= we_q;
            ram_din_a_q  <= we_q ? wdata_q[23:16] : 8'h0;
            ram_din_b_q  <= we_q ? wdata_q[31:24] : 8'h0;
          end else if (we_q) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b1;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_ACC1: begin
          // Read data for the ACC0 addresses is on the RAM outputs now.
          rdata_lo_q <= {ram_dout_b, ram_dout_a};
          if (we_q) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b1;
          end else begin
            state_q <= S_WAIT;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= load_data_d;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: byte-array RAM model with registered reads, a
// reference byte memory plus latency table predicting every response, and a
// per-cycle compare process; directed cases pin the model with literals.
module tb_dmem_access_ctrl;

  localparam int AW = 15;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_unsigned = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = 32'h0;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [7:0]    ram_din_a, ram_din_b;
  logic          ram_we_a, ram_we_b;
  logic [7:0]    ram_dout_a = 8'h0;
  logic [7:0]    ram_dout_b = 8'h0;

  int total = 0;
  int bad = 0;

  dmem_access_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_addr_a(ram_addr_a), .ram_din_a(ram_din_a), .ram_we_a(ram_we_a),
    .ram_dout_a(ram_dout_a),
    .ram_addr_b(ram_addr_b), .ram_din_b(ram_din_b), .ram_we_b(ram_we_b),
    .ram_dout_b(ram_dout_b)
  );

  always #5 clk = ~clk;

  // Dual-port RAM model: synchronous write, registered read.
  logic [7:0] mem [0:DEPTH-1];
  logic [7:0] ref_mem [0:DEPTH-1];
  bit mem_ready = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] = 8'($urandom);
        ref_mem[i] = mem[i];
      end
      mem_ready = 1'b1;
    end
    ram_dout_a <= mem[ram_addr_a];
    ram_dout_b <= mem[ram_addr_b];
    if (ram_we_a) mem[ram_addr_a] = ram_din_a;
    if (ram_we_b) mem[ram_addr_b] = ram_din_b;
  end

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        expq[$];
  int          ncyc = 0;
  bit          chk_en = 1'b0;
  logic [31:0] last_rdata;
  logic        last_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, ncyc);
    end
  endtask

  // Compare process: every cycle, outputs must match what the model says is due.
  always @(negedge clk) begin
    bit busy;
    ncyc++;
    if (chk_en) begin
      busy = (expq.size() > 0) && (expq[0].due > ncyc);
      check("req_ready", 32'(req_ready), 32'(!busy));
      if (expq.size() > 0 && expq[0].due == ncyc) begin
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_rdata", rsp_rdata, expq[0].rdata);
        check("rsp_err", 32'(rsp_err), 32'(expq[0].err));
        last_rdata = rsp_rdata;
        last_err = rsp_err;
        $display("rsp cycle=%0d rdata=0x%08h err=%0d", ncyc, rsp_rdata, rsp_err);
        void'(expq.pop_front());
      end else begin
        check("rsp_valid_idle", 32'(rsp_valid), 32'd0);
      end
      if (!busy) begin
        check("ram_we_idle", {30'd0, ram_we_a, ram_we_b}, 32'd0);
        check("ram_bus_idle", {1'b0, ram_addr_a, ram_addr_b[AW-1:0] != 0, ram_din_a, ram_din_b},
              32'd0);
      end
    end
  end

  // Reference model: what the request must return and after how many cycles.
  task automatic model_accept(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [AW-1:0] a, input logic [31:0] wd);
    exp_t e;
    int nb, lat;
    logic [31:0] v;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    v = 32'h0;
    if (sz == 2'd3) lat = 1;
    else if (nb == 4) lat = we ? 3 : 4;
    else lat = we ? 2 : 3;
    if (sz != 2'd3) begin
      for (int i = 0; i < nb; i++) begin
        int ad;
        ad = (int'(a) + i) % DEPTH;
        if (we) ref_mem[ad] = wd[8*i +: 8];
        else v = v | (32'(ref_mem[ad]) << (8 * i));
      end
      if (!we && !uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFFFFFF << (8 * nb));
      if (we) v = 32'h0;
    end
    e.due = ncyc + lat;
    e.rdata = v;
    e.err = (sz == 2'd3);
    expq.push_back(e);
    $display("req cycle=%0d we=%0d size=%0d uns=%0d addr=0x%04h wdata=0x%08h exp=0x%08h lat=%0d",
             ncyc, we, sz, uns, a, wd, v, lat);
  endtask

  // Present a request (called just after a falling edge); returns after the accept edge.
  task automatic send(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [AW-1:0] a, input logic [31:0] wd);
    int n;
    req_valid = 1'b1;
    req_we = we;
    req_size = sz;
    req_unsigned = uns;
    req_addr = a;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: req_ready got 0 expected 1 within 40 cycles");
      req_valid = 1'b0;
      @(negedge clk);
      return;
    end
    @(posedge clk);
    model_accept(we, sz, uns, a, wd);
    @(negedge clk);
  endtask

  task automatic wait_done();
    int n;
    req_valid = 1'b0;
    n = 0;
    while (expq.size() > 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (expq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL rsp_timeout: %0d responses outstanding, expected 0", expq.size());
      expq.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] keep2, keep3;
    int diffs;
    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(req_ready), 32'd1);
    check("reset_rsp", {rsp_valid, rsp_err, 30'd0}, 32'd0);
    check("reset_rdata", rsp_rdata, 32'h0);
    check("reset_we", {30'd0, ram_we_a, ram_we_b}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;

    // Word store / load round trip.
    send(1'b1, 2'b10, 1'b0, 15'h0100, 32'hDEADBEEF);
    wait_done();
    check("t1_mem100", 32'(mem[15'h100]), 32'hEF);
    check("t1_mem101", 32'(mem[15'h101]), 32'hBE);
    check("t1_mem102", 32'(mem[15'h102]), 32'hAD);
    check("t1_mem103", 32'(mem[15'h103]), 32'hDE);
    send(1'b0, 2'b10, 1'b1, 15'h0100, 32'h0);
    wait_done();
    check("t1_load", last_rdata, 32'hDEADBEEF);

    // Byte store, signed and unsigned load; upper wdata bytes must not land.
    keep2 = mem[15'h0006];
    send(1'b1, 2'b00, 1'b0, 15'h0005, 32'h5A5A5A80);
    wait_done();
    check("t2_mem5", 32'(mem[15'h5]), 32'h80);
    check("t2_mem6", 32'(mem[15'h6]), 32'(keep2));
    send(1'b0, 2'b00, 1'b0, 15'h0005, 32'h0);
    wait_done();
    check("t2_signed", last_rdata, 32'hFFFFFF80);
    send(1'b0, 2'b00, 1'b1, 15'h0005, 32'h0);
    wait_done();
    check("t2_unsigned", last_rdata, 32'h00000080);

    // Half store across the top of the address space.
    send(1'b1, 2'b01, 1'b0, 15'h7FFF, 32'h00001234);
    wait_done();
    check("t3_mem7fff", 32'(mem[15'h7FFF]), 32'h34);
    check("t3_mem0", 32'(mem[15'h0000]), 32'h12);
    send(1'b0, 2'b01, 1'b0, 15'h7FFF, 32'h0);
    wait_done();
    check("t3_load", last_rdata, 32'h00001234);

    // Illegal size.
    send(1'b0, 2'b11, 1'b0, 15'h0100, 32'h0);
    wait_done();
    check("t4_err", 32'(last_err), 32'd1);
    check("t4_rdata", last_rdata, 32'h0);

    // Back-to-back loads with req_valid held high.
    send(1'b0, 2'b10, 1'b0, 15'h0100, 32'h0);
    send(1'b0, 2'b00, 1'b1, 15'h0101, 32'h0);
    send(1'b0, 2'b01, 1'b0, 15'h0102, 32'h0);
    wait_done();
    check("t5_last", last_rdata, 32'hFFFFDEAD);

    // Reset during ACC1 of a word store.
    chk_en = 1'b0;
    keep2 = mem[15'h0202];
    keep3 = mem[15'h0203];
    req_valid = 1'b1;
    req_we = 1'b1;
    req_size = 2'b10;
    req_addr = 15'h0200;
    req_wdata = 32'h11223344;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t6_we_drop", {30'd0, ram_we_a, ram_we_b}, 32'd0);
    ref_mem[15'h0200] = 8'h44;
    ref_mem[15'h0201] = 8'h33;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_ready", 32'(req_ready), 32'd1);
    check("t6_mem200", 32'(mem[15'h200]), 32'h44);
    check("t6_mem201", 32'(mem[15'h201]), 32'h33);
    check("t6_mem202", 32'(mem[15'h202]), 32'(keep2));
    check("t6_mem203", 32'(mem[15'h203]), 32'(keep3));
    chk_en = 1'b1;
    repeat (4) @(negedge clk);

    // Randomized traffic.
    for (int k = 0; k < 300; k++) begin
      logic [AW-1:0] a;
      logic [1:0] sz;
      int r;
      r = $urandom_range(0, 3);
      if (r == 0) a = AW'($urandom_range(32'h7FF8, 32'h7FFF));
      else if (r == 1) a = AW'($urandom);
      else a = AW'($urandom_range(32'h0100, 32'h011F));
      r = $urandom_range(0, 7);
      sz = (r < 2) ? 2'b00 : (r < 4) ? 2'b01 : (r < 7) ? 2'b10 : 2'b11;
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        @(negedge clk);
      end
      send(1'($urandom), sz, 1'($urandom), a, $urandom);
    end
    wait_done();

    // Whole memory must match the reference.
    diffs = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i] !== ref_mem[i]) begin
        if (diffs < 4) $display("mem diff at 0x%04h: 0x%02h vs 0x%02h", i, mem[i], ref_mem[i]);
        diffs++;
      end
    end
    check("mem_final_diffs", 32'(diffs), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
